// File: rtl/axi_pkg.sv
// Shared AXI4 widths, response codes and FSM state types for the
// interconnect slave ports.
package axi_pkg;

    localparam int IDS_BITS  = 8;
    localparam int ADDR_BITS = 32;
    localparam int LEN_BITS  = 4;
    localparam int SIZE_BITS = 3;
    localparam int DATA_BITS = 32;
    localparam int STRB_BITS = 4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi_default_slave_if.sv
// AXI4 slave-port bundle for the default responder.
// The master modport is the interconnect side, the slave modport the responder.
interface axi_default_slave_if;
    import axi_pkg::*;

    logic [IDS_BITS-1:0]  AWID_S;
    logic [ADDR_BITS-1:0] AWADDR_S;
    logic [LEN_BITS-1:0]  AWLEN_S;
    logic [SIZE_BITS-1:0] AWSIZE_S;
    logic [1:0]           AWBURST_S;
    logic                 AWVALID_S;
    logic                 AWREADY_S;

    logic [DATA_BITS-1:0] WDATA_S;
    logic [STRB_BITS-1:0] WSTRB_S;
    logic                 WLAST_S;
    logic                 WVALID_S;
    logic                 WREADY_S;

    logic [IDS_BITS-1:0]  BID_S;
    logic [1:0]           BRESP_S;
    logic                 BVALID_S;
    logic                 BREADY_S;

    logic [IDS_BITS-1:0]  ARID_S;
    logic [ADDR_BITS-1:0] ARADDR_S;
    logic [LEN_BITS-1:0]  ARLEN_S;
    logic [SIZE_BITS-1:0] ARSIZE_S;
    logic [1:0]           ARBURST_S;
    logic                 ARVALID_S;
    logic                 ARREADY_S;

    logic [IDS_BITS-1:0]  RID_S;
    logic [DATA_BITS-1:0] RDATA_S;
    logic [1:0]           RRESP_S;
    logic                 RLAST_S;
    logic                 RVALID_S;
    logic                 RREADY_S;

    modport slave (
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S,
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        output ARREADY_S,
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S
    );

    modport master (
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S,
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        input  ARREADY_S,
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S
    );

endinterface

// File: rtl/axi_default_slave.sv
// Default AXI4 responder: completes every unmapped transaction with DECERR.
// Independent write (AW/W/B) and read (AR/R) FSMs, no storage.
module axi_default_slave
    import axi_pkg::*;
(
    input  logic ACLK,
    input  logic ARESETn,
    axi_default_slave_if.slave s
);

    wr_state_e w_state;
    wr_state_e w_next;
    rd_state_e r_state;
    rd_state_e r_next;

    logic                up_q;
    logic [IDS_BITS-1:0] bid_q;
    logic [IDS_BITS-1:0] rid_q;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] cnt_q;

    logic aw_hs;
    logic w_last_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic r_last;

    // Payload fields that a default responder has no use for.
    logic unused_inputs;
    assign unused_inputs = ^{s.AWADDR_S, s.AWLEN_S, s.AWSIZE_S,
                             s.AWBURST_S, s.WDATA_S, s.WSTRB_S,
                             s.ARADDR_S, s.ARSIZE_S, s.ARBURST_S};

    // Keeps AWREADY/ARREADY low until the first cycle after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) up_q <= 1'b0;
        else          up_q <= 1'b1;
    end

    // Handshake decode from registered state and master valid/ready.
    always_comb begin
        aw_hs     = up_q && (w_state == W_IDLE) && s.AWVALID_S;
        w_last_hs = (w_state == W_DATA) && s.WVALID_S && s.WLAST_S;
        b_hs      = (w_state == W_RESP) && s.BREADY_S;
        ar_hs     = up_q && (r_state == R_IDLE) && s.ARVALID_S;
        r_last    = (r_state == R_DATA) && (cnt_q == len_q);
        r_hs      = (r_state == R_DATA) && s.RREADY_S;
    end

    // Write FSM next state.
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs)     w_next = W_DATA;
            W_DATA:  if (w_last_hs) w_next = W_RESP;
            W_RESP:  if (b_hs)      w_next = W_IDLE;
            default:                w_next = W_IDLE;
        endcase
    end

    // Write FSM state and captured BID.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            bid_q   <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) bid_q <= s.AWID_S;
        end
    end

    // Read FSM next state.
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs)          r_next = R_DATA;
            R_DATA:  if (r_hs && r_last) r_next = R_IDLE;
            default:                     r_next = R_IDLE;
        endcase
    end

    // Read FSM state, captured RID/length and beat counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            rid_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rid_q <= s.ARID_S;
                len_q <= s.ARLEN_S;
                cnt_q <= '0;
            end else if (r_hs && !r_last) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        s.AWREADY_S = up_q && (w_state == W_IDLE);
        s.WREADY_S  = (w_state == W_DATA);
        s.BVALID_S  = (w_state == W_RESP);
        s.BID_S     = bid_q;
        s.BRESP_S   = (w_state == W_RESP) ? DECERR : OKAY;
        s.ARREADY_S = up_q && (r_state == R_IDLE);
        s.RVALID_S  = (r_state == R_DATA);
        s.RID_S     = rid_q;
        s.RDATA_S   = '0;
        s.RRESP_S   = (r_state == R_DATA) ? DECERR : OKAY;
        s.RLAST_S   = r_last;
    end

endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: randomized master traffic, expected
// responses queued at issue time and checked by an independent monitor.
module tb_axi_default_slave;

    typedef struct {
        logic [7:0] id;
        logic       last;
    } rbeat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int b_mode = 0;
    int r_mode = 0;

    logic [7:0] exp_b[$];
    rbeat_t     exp_r[$];

    always #5 clk = ~clk;

    axi_default_slave_if bus();

    axi_default_slave dut (
        .ACLK(clk),
        .ARESETn(rst_n),
        .s(bus.slave)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S, bus.BID_S,
                    bus.BRESP_S, bus.ARREADY_S, bus.RVALID_S, bus.RID_S,
                    bus.RDATA_S, bus.RRESP_S, bus.RLAST_S});
    endfunction

    // ch: 0 = AWREADY, 1 = WREADY, 2 = ARREADY; n = negedges waited.
    task automatic wait_ready(input int ch, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if ((ch == 0 && bus.AWREADY_S) || (ch == 1 && bus.WREADY_S) ||
                (ch == 2 && bus.ARREADY_S)) break;
            n++;
            if (n > 500) begin
                tmo("ready_wait");
                break;
            end
        end
    endtask

    task automatic do_write(input logic [7:0] id, input int beats,
                            input bit gaps);
        int n;
        bus.AWVALID_S = 1'b1;
        bus.AWID_S    = id;
        bus.AWADDR_S  = $urandom;
        bus.AWLEN_S   = 4'($urandom);
        bus.AWSIZE_S  = 3'd2;
        bus.AWBURST_S = 2'd1;
        wait_ready(0, n);
        exp_b.push_back(id);
        tick();
        bus.AWVALID_S = 1'b0;
        for (int i = 0; i < beats; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            bus.WVALID_S = 1'b1;
            bus.WLAST_S  = (i == beats - 1);
            bus.WDATA_S  = $urandom;
            bus.WSTRB_S  = 4'($urandom);
            wait_ready(1, n);
            if (i == 0) begin
                chk("aw_busy", 64'(bus.AWREADY_S), 64'd0);
                if (!gaps) chk("wready_latency", 64'(n), 64'd0);
            end
            tick();
            bus.WVALID_S = 1'b0;
            bus.WLAST_S  = 1'b0;
        end
        @(negedge clk);
        chk("b_latency", 64'(bus.BVALID_S), 64'd1);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [3:0] len);
        int n;
        rbeat_t bt;
        bus.ARVALID_S = 1'b1;
        bus.ARID_S    = id;
        bus.ARLEN_S   = len;
        bus.ARADDR_S  = $urandom;
        bus.ARSIZE_S  = 3'd2;
        bus.ARBURST_S = 2'd1;
        wait_ready(2, n);
        for (int i = 0; i <= int'(len); i++) begin
            bt.id   = id;
            bt.last = (i == int'(len));
            exp_r.push_back(bt);
        end
        tick();
        bus.ARVALID_S = 1'b0;
        @(negedge clk);
        chk("r_latency", 64'(bus.RVALID_S), 64'd1);
        chk("ar_busy", 64'(bus.ARREADY_S), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(negedge clk);
            if (exp_b.size() == 0 && exp_r.size() == 0 &&
                !bus.BVALID_S && !bus.RVALID_S) break;
            n++;
            if (n > 2000) begin
                tmo("drain");
                break;
            end
        end
    endtask

    // BREADY driver: 0 = high, 1 = random, 2 = low.
    initial forever begin
        @(posedge clk);
        #1;
        bus.BREADY_S = (b_mode == 0) ? 1'b1 :
                       (b_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // RREADY driver: 0 = high, 1 = random.
    initial forever begin
        @(posedge clk);
        #1;
        bus.RREADY_S = (r_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // Monitor: compares every presented B/R against the head of its queue.
    initial begin
        bit b_stall = 0;
        bit r_stall = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_stall = 0;
                r_stall = 0;
            end else begin
                if (b_stall) chk("b_valid_hold", 64'(bus.BVALID_S), 64'd1);
                if (bus.BVALID_S) begin
                    if (exp_b.size() == 0) begin
                        tmo("b_unexpected");
                    end else begin
                        chk("bid", 64'(bus.BID_S), 64'(exp_b[0]));
                        chk("bresp", 64'(bus.BRESP_S), 64'd3);
                        if (bus.BREADY_S) void'(exp_b.pop_front());
                    end
                end
                b_stall = bus.BVALID_S && !bus.BREADY_S;
                if (r_stall) chk("r_valid_hold", 64'(bus.RVALID_S), 64'd1);
                if (bus.RVALID_S) begin
                    if (exp_r.size() == 0) begin
                        tmo("r_unexpected");
                    end else begin
                        chk("rid", 64'(bus.RID_S), 64'(exp_r[0].id));
                        chk("rlast", 64'(bus.RLAST_S), 64'(exp_r[0].last));
                        chk("rdata", 64'(bus.RDATA_S), 64'd0);
                        chk("rresp", 64'(bus.RRESP_S), 64'd3);
                        if (bus.RREADY_S) void'(exp_r.pop_front());
                    end
                end
                r_stall = bus.RVALID_S && !bus.RREADY_S;
            end
        end
    end

    initial begin
        int n;
        bus.AWVALID_S = 1'b0;
        bus.AWID_S    = '0;
        bus.AWADDR_S  = '0;
        bus.AWLEN_S   = '0;
        bus.AWSIZE_S  = '0;
        bus.AWBURST_S = '0;
        bus.WVALID_S  = 1'b0;
        bus.WLAST_S   = 1'b0;
        bus.WDATA_S   = '0;
        bus.WSTRB_S   = '0;
        bus.ARVALID_S = 1'b0;
        bus.ARID_S    = '0;
        bus.ARADDR_S  = '0;
        bus.ARLEN_S   = '0;
        bus.ARSIZE_S  = '0;
        bus.ARBURST_S = '0;
        bus.BREADY_S  = 1'b0;
        bus.RREADY_S  = 1'b0;

        // Reset: outputs zero, ready one cycle after release.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", all_outs(), 64'd0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("awready_post_reset", 64'(bus.AWREADY_S), 64'd1);
        chk("arready_post_reset", 64'(bus.ARREADY_S), 64'd1);

        // W before AW must stall.
        tick();
        bus.WVALID_S = 1'b1;
        bus.WLAST_S  = 1'b1;
        @(negedge clk);
        chk("w_stall_idle", 64'(bus.WREADY_S), 64'd0);
        tick();
        bus.WVALID_S = 1'b0;
        bus.WLAST_S  = 1'b0;

        // Single write.
        do_write(8'h15, 1, 0);
        drain();

        // Read burst of 4.
        tick();
        do_read(8'h22, 4'd3);
        drain();
        @(negedge clk);
        chk("arready_after_read", 64'(bus.ARREADY_S), 64'd1);

        // Backpressure: 16-beat read with random RREADY, BREADY low 5 cycles.
        tick();
        r_mode = 1;
        b_mode = 2;
        fork
            do_read(8'h3C, 4'd15);
            begin
                do_write(8'h47, 3, 0);
                repeat (5) tick();
                b_mode = 0;
            end
        join
        drain();
        r_mode = 0;

        // Concurrent read and write issued together.
        tick();
        fork
            do_write(8'h01, 4, 0);
            do_read(8'h02, 4'd1);
        join
        drain();

        // Randomized mixed traffic.
        b_mode = 1;
        r_mode = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            fork
                do_write(8'($urandom), int'($urandom_range(1, 8)), 1);
                do_read(8'($urandom), 4'($urandom));
            join
        end
        drain();
        b_mode = 0;
        r_mode = 0;

        // Mid-burst reset after two beats of an 8-beat read.
        tick();
        do_read(8'h5A, 4'd7);
        n = 0;
        while (exp_r.size() != 6 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) tmo("mid_reset_wait");
        #1;
        rst_n = 1'b0;
        exp_r.delete();
        exp_b.delete();
        #1;
        chk("mid_reset_outs", all_outs(), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        do_read(8'h66, 4'd2);
        drain();

        chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
        chk("r_queue_empty", 64'(exp_r.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
